// File: rtl/reg_file_pkg.sv
// Shared types and constants for the decode-stage register file and its branch comparator.
package reg_file_pkg;

    localparam int                    SB_CNT_W   = 2;
    localparam logic [SB_CNT_W-1:0]   SB_CNT_MAX = 2'd3;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5,
        CMP_LTZ = 3'd6,
        CMP_GEZ = 3'd7
    } cmp_mode_e;

    // Zero-against-operand modes only look at operand A.
    function automatic logic cmp_uses_b(input cmp_mode_e mode);
        return !((mode == CMP_LTZ) || (mode == CMP_GEZ));
    endfunction

endpackage

// File: rtl/reg_file_sb_branch_cmp.sv
// Combinational branch comparator; shared with the EX-stage branch unit.
module branch_cmp
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  cmp_mode_e         cmp_mode,
    output logic              cmp_out
);

    logic lt_s_s;
    logic lt_u_s;
    logic eq_s;

    assign lt_s_s = ($signed(a) < $signed(b));
    assign lt_u_s = (a < b);
    assign eq_s   = (a == b);

    // Mode decode of the shared compare results.
    always_comb begin
        cmp_out = 1'b0;
        case (cmp_mode)
            CMP_EQ:  cmp_out = eq_s;
            CMP_NE:  cmp_out = !eq_s;
            CMP_LT:  cmp_out = lt_s_s;
            CMP_GE:  cmp_out = !lt_s_s;
            CMP_LTU: cmp_out = lt_u_s;
            CMP_GEU: cmp_out = !lt_u_s;
            CMP_LTZ: cmp_out = a[DATA_W-1];
            CMP_GEZ: cmp_out = !a[DATA_W-1];
            default: cmp_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass, per-register pending-write scoreboard
// and an early branch comparator on read ports 0 and 1.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          issue_en,
    input  logic [ADDR_W-1:0]             issue_addr,
    output logic [NUM_RD-1:0]             pending,
    input  cmp_mode_e                     cmp_mode,
    output logic                          cmp_out,
    output logic                          cmp_valid,
    output logic                          sb_err
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_q  [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d  [NUM_REGS];
    logic                sb_err_q;
    logic                sb_err_d;

    logic                wr_store_s;
    logic                wr_fwd_s;

    // Writes to r0 never land; forwarding is suppressed while reset is applied.
    assign wr_store_s = wr_en && (wr_addr != {ADDR_W{1'b0}});
    assign wr_fwd_s   = (BYPASS != 0) && wr_en && !rst;

    // Next-state register contents.
    always_comb begin
        regs_d[0] = {DATA_W{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            regs_d[r] = (wr_store_s && (wr_addr == ADDR_W'(r))) ? wr_data : regs_q[r];
        end
    end

    // Scoreboard counters: issue increments, writeback decrements, both cancel.
    always_comb begin
        logic inc_s;
        logic dec_s;
        inc_s     = 1'b0;
        dec_s     = 1'b0;
        sb_err_d  = sb_err_q;
        cnt_d[0]  = {SB_CNT_W{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_s    = issue_en && (issue_addr == ADDR_W'(r));
            dec_s    = wr_en && (wr_addr == ADDR_W'(r));
            cnt_d[r] = cnt_q[r];
            case ({inc_s, dec_s})
                2'b10: begin
                    if (cnt_q[r] == SB_CNT_MAX) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + 2'd1;
                    end
                end
                2'b01: begin
                    if (cnt_q[r] == 2'd0) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - 2'd1;
                    end
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
                cnt_q[r]  <= {SB_CNT_W{1'b0}};
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Read ports: r0 reads zero, forwarding beats storage, and the last
    // outstanding write stops being pending once it is forwarded.
    always_comb begin
        logic                hit_s;
        logic [SB_CNT_W-1:0] cnt_s;
        hit_s = 1'b0;
        cnt_s = {SB_CNT_W{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            hit_s = wr_fwd_s && (wr_addr == rd_addr[i]);
            cnt_s = cnt_q[rd_addr[i]];
            if (rd_addr[i] == {ADDR_W{1'b0}}) begin
                rd_data[i] = {DATA_W{1'b0}};
            end else if (hit_s) begin
                rd_data[i] = wr_data;
            end else begin
                rd_data[i] = regs_q[rd_addr[i]];
            end
            pending[i] = (cnt_s != 2'd0) && !(hit_s && (cnt_s == 2'd1));
        end
    end

    branch_cmp #(
        .DATA_W   (DATA_W)
    ) u_branch_cmp (
        .a        (rd_data[0]),
        .b        (rd_data[1]),
        .cmp_mode (cmp_mode),
        .cmp_out  (cmp_out)
    );

    assign cmp_valid = !pending[0] && (!cmp_uses_b(cmp_mode) || !pending[1]);
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench: default config, a BYPASS=0 twin on the same
// stimulus, and a 16x64 three-port instance.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;

    logic [1:0][4:0]  rd_addr = '0;
    logic [1:0][31:0] rd_data, nb_rd_data;
    logic             wr_en = 1'b0;
    logic [4:0]       wr_addr = 5'd0;
    logic [31:0]      wr_data = 32'd0;
    logic             issue_en = 1'b0;
    logic [4:0]       issue_addr = 5'd0;
    logic [1:0]       pending, nb_pending;
    cmp_mode_e        cmp_mode = CMP_EQ;
    logic             cmp_out, cmp_valid, sb_err;
    logic             nb_cmp_out, nb_cmp_valid, nb_sb_err;

    logic [2:0][3:0]  w_rd_addr = '0;
    logic [2:0][63:0] w_rd_data;
    logic             w_wr_en = 1'b0;
    logic [3:0]       w_wr_addr = 4'd0;
    logic [63:0]      w_wr_data = 64'd0;
    logic             w_issue_en = 1'b0;
    logic [3:0]       w_issue_addr = 4'd0;
    logic [2:0]       w_pending;
    cmp_mode_e        w_cmp_mode = CMP_EQ;
    logic             w_cmp_out, w_cmp_valid, w_sb_err;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0]  exp_zero = 8'b1010_1001;
    logic [7:0]  exp_neg1 = 8'b0110_0110;
    logic [63:0] wide_val = 64'h8000_0000_0000_0001;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pending(pending),
        .cmp_mode(cmp_mode), .cmp_out(cmp_out), .cmp_valid(cmp_valid), .sb_err(sb_err)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pending(nb_pending),
        .cmp_mode(cmp_mode), .cmp_out(nb_cmp_out), .cmp_valid(nb_cmp_valid), .sb_err(nb_sb_err)
    );

    reg_file_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(3)) dut_w (
        .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .issue_en(w_issue_en), .issue_addr(w_issue_addr), .pending(w_pending),
        .cmp_mode(w_cmp_mode), .cmp_out(w_cmp_out), .cmp_valid(w_cmp_valid), .sb_err(w_sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_sb_err", 64'(sb_err), 64'd0);
        chk("rst_cmp_valid", 64'(cmp_valid), 64'd1);
        for (int m = 0; m < 8; m++) begin
            cmp_mode = cmp_mode_e'(m);
            #1;
            chk($sformatf("rst_cmp_mode%0d", m), 64'(cmp_out), 64'(exp_zero[m]));
        end
        cmp_mode = CMP_EQ;
        for (int r = 0; r < 32; r++) begin
            rd_addr[0] = 5'(r);
            rd_addr[1] = 5'(31 - r);
            #1;
            chk($sformatf("rst_rd0_r%0d", r), 64'(rd_data[0]), 64'd0);
            chk($sformatf("rst_rd1_r%0d", r), 64'(rd_data[1]), 64'd0);
            chk($sformatf("rst_pend_r%0d", r), 64'(pending), 64'd0);
            step();
        end

        // r0 writes are dropped and not forwarded.
        rd_addr = '0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        #1;
        chk("r0_fwd", 64'(rd_data[0]), 64'd0);
        step();
        wr_en = 1'b0;
        #1;
        chk("r0_stored", 64'(rd_data[0]), 64'd0);
        chk("r0_sb_err", 64'(sb_err), 64'd0);

        // Bypass vs no bypass on r5.
        issue_en = 1'b1; issue_addr = 5'd5;
        step();
        issue_en = 1'b0;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
        #1;
        chk("r5_pend_after_issue", 64'(pending[0]), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        #1;
        chk("r5_bypass_data", 64'(rd_data[0]), 64'h12345678);
        chk("r5_bypass_pend", 64'(pending[0]), 64'd0);
        chk("r5_nb_old_data", 64'(nb_rd_data[0]), 64'd0);
        chk("r5_nb_pend", 64'(nb_pending[0]), 64'd1);
        step();
        wr_en = 1'b0;
        #1;
        chk("r5_stored", 64'(rd_data[1]), 64'h12345678);
        chk("r5_nb_stored", 64'(nb_rd_data[0]), 64'h12345678);
        chk("r5_nb_pend_clr", 64'(nb_pending[0]), 64'd0);
        chk("r5_sb_err", 64'(sb_err), 64'd0);

        // Two issues to r7, two writes.
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        step();
        issue_en = 1'b0;
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd5;
        #1;
        chk("r7_pend_cnt2", 64'(pending[0]), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #1;
        chk("r7_pend_first_wr", 64'(pending[0]), 64'd1);
        chk("r7_cmp_valid_first_wr", 64'(cmp_valid), 64'd0);
        step();
        wr_data = 32'h88;
        #1;
        chk("r7_pend_last_wr", 64'(pending[0]), 64'd0);
        chk("r7_cmp_valid_last_wr", 64'(cmp_valid), 64'd1);
        chk("r7_fwd_data", 64'(rd_data[0]), 64'h88);
        step();
        wr_en = 1'b0;
        #1;
        chk("r7_pend_done", 64'(pending[0]), 64'd0);

        // Issue + write on r3 in the same cycle, then overflow.
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        rd_addr[0] = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        chk("r3_same_cycle_pend", 64'(pending[0]), 64'd0);
        step();
        wr_en = 1'b0;
        #1;
        chk("r3_cnt_held", 64'(pending[0]), 64'd1);
        chk("r3_data", 64'(rd_data[0]), 64'h33);
        step();
        step();
        chk("r3_cnt3_no_err", 64'(sb_err), 64'd0);
        step();
        chk("r3_overflow_err", 64'(sb_err), 64'd1);
        issue_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        step();
        wr_en = 1'b0;
        #1;
        chk("r3_err_sticky", 64'(sb_err), 64'd1);
        chk("r3_still_pend", 64'(pending[0]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_addr[1] = 5'd5;
        #1;
        chk("rst2_sb_err", 64'(sb_err), 64'd0);
        chk("rst2_pend", 64'(pending), 64'd0);
        chk("rst2_r3", 64'(rd_data[0]), 64'd0);
        chk("rst2_r5", 64'(rd_data[1]), 64'd0);

        // Write with no outstanding issue underflows.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
        step();
        wr_en = 1'b0;
        #1;
        chk("underflow_err", 64'(sb_err), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Comparator: A=-1, B=1.
        issue_en = 1'b1; issue_addr = 5'd1;
        step();
        issue_addr = 5'd2;
        step();
        issue_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFFFFFF;
        step();
        wr_addr = 5'd2; wr_data = 32'd1;
        step();
        wr_en = 1'b0;
        rd_addr[0] = 5'd1; rd_addr[1] = 5'd2;
        #1;
        chk("cmp_sb_err", 64'(sb_err), 64'd0);
        for (int m = 0; m < 8; m++) begin
            cmp_mode = cmp_mode_e'(m);
            #1;
            chk($sformatf("cmp_mode%0d", m), 64'(cmp_out), 64'(exp_neg1[m]));
            chk($sformatf("cmp_valid_mode%0d", m), 64'(cmp_valid), 64'd1);
        end
        issue_en = 1'b1; issue_addr = 5'd2;
        step();
        issue_en = 1'b0;
        cmp_mode = CMP_LT;
        #1;
        chk("cmp_lt_b_pend_valid", 64'(cmp_valid), 64'd0);
        cmp_mode = CMP_LTZ;
        #1;
        chk("cmp_ltz_b_pend_valid", 64'(cmp_valid), 64'd1);
        chk("cmp_ltz_b_pend_out", 64'(cmp_out), 64'd1);

        // Wide three-port instance.
        w_issue_en = 1'b1; w_issue_addr = 4'd15;
        step();
        w_issue_en = 1'b0;
        w_rd_addr[0] = 4'd15; w_rd_addr[1] = 4'd15; w_rd_addr[2] = 4'd15;
        w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = wide_val;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("w_fwd_p%0d", p), w_rd_data[p], wide_val);
        end
        step();
        w_wr_en = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("w_stored_p%0d", p), w_rd_data[p], wide_val);
        end
        chk("w_pend", 64'(w_pending), 64'd0);
        chk("w_sb_err", 64'(w_sb_err), 64'd0);
        w_rd_addr[1] = 4'd0;
        w_cmp_mode = CMP_LT;
        #1;
        chk("w_lt_zero", 64'(w_cmp_out), 64'd1);
        chk("w_lt_valid", 64'(w_cmp_valid), 64'd1);
        w_cmp_mode = CMP_GE;
        #1;
        chk("w_ge_zero", 64'(w_cmp_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
